// File: rtl/md_pkg.sv
// Shared encodings and defaults for the multiply/divide scheduler and its datapath.
package md_pkg;

  localparam logic [3:0] MD_NONE  = 4'd0;
  localparam logic [3:0] MD_MULT  = 4'd1;
  localparam logic [3:0] MD_MULTU = 4'd2;
  localparam logic [3:0] MD_DIV   = 4'd3;
  localparam logic [3:0] MD_DIVU  = 4'd4;
  localparam logic [3:0] MD_MTHI  = 4'd5;
  localparam logic [3:0] MD_MTLO  = 4'd6;
  localparam logic [3:0] MD_MFHI  = 4'd7;
  localparam logic [3:0] MD_MFLO  = 4'd8;

  localparam int MD_MULT_CYCLES = 5;
  localparam int MD_DIV_CYCLES  = 10;

  typedef enum logic {MD_IDLE, MD_RUN} md_state_e;

  // Ops that launch a busy period and produce a pending HI/LO pair.
  function automatic logic md_is_arith(input logic [3:0] op);
    return (op >= MD_MULT) && (op <= MD_DIVU);
  endfunction

endpackage

// File: rtl/md_alu.sv
// Purpose: one-step combinational mult/multu/div/divu producing {hi, lo, div_by_zero}.
// Latency: zero cycles (pure combinational).
// Backpressure: none; the scheduler decides when the result is captured.
module md_alu
  import md_pkg::*;
(
  input  logic [3:0]  op,
  input  logic [31:0] rs,
  input  logic [31:0] rt,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        div_by_zero
);

  logic        is_signed;
  logic        is_div;
  logic [63:0] a64;
  logic [63:0] b64;
  logic [63:0] prod;
  logic        neg_q;
  logic        neg_r;
  logic [31:0] ua;
  logic [31:0] ub;
  logic [31:0] ub_safe;
  logic [31:0] uq;
  logic [31:0] ur;

  always_comb begin
    is_signed   = (op == MD_MULT) || (op == MD_DIV);
    is_div      = (op == MD_DIV) || (op == MD_DIVU);
    a64         = is_signed ? {{32{rs[31]}}, rs} : {32'b0, rs};
    b64         = is_signed ? {{32{rt[31]}}, rt} : {32'b0, rt};
    prod        = a64 * b64;
    // Signed divide on magnitudes: INT_MIN / -1 wraps back to INT_MIN with no special case.
    neg_r       = (op == MD_DIV) & rs[31];
    neg_q       = (op == MD_DIV) & (rs[31] ^ rt[31]);
    ua          = neg_r ? -rs : rs;
    ub          = ((op == MD_DIV) & rt[31]) ? -rt : rt;
    div_by_zero = is_div & (rt == 32'd0);
    ub_safe     = (rt == 32'd0) ? 32'd1 : ub;
    uq          = ua / ub_safe;
    ur          = ua % ub_safe;
    hi          = '0;
    lo          = '0;
    if (op == MD_MULT || op == MD_MULTU) begin
      hi = prod[63:32];
      lo = prod[31:0];
    end else if (is_div) begin
      hi = neg_r ? -ur : ur;
      lo = neg_q ? -uq : uq;
    end
  end

endmodule

// File: rtl/md_sched.sv
// Purpose: sequences multi-cycle mult/div, owns HI/LO, raises the D-stage stall.
// Latency: result visible MULT_CYCLES+1 / DIV_CYCLES+1 cycles after issue; MT ops write next edge.
// Backpressure: stall_md holds md-class ops in D while start or busy; ops arriving busy are dropped.
module md_sched
  import md_pkg::*;
#(
  parameter int MULT_CYCLES = MD_MULT_CYCLES,
  parameter int DIV_CYCLES  = MD_DIV_CYCLES
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  E_md_op,
  input  logic        E_valid,
  input  logic [31:0] E_rs_data,
  input  logic [31:0] E_rt_data,
  input  logic        D_md_use,
  output logic        start,
  output logic        busy,
  output logic        stall_md,
  output logic [31:0] E_md_rd,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  localparam int MAX_CYC = (DIV_CYCLES > MULT_CYCLES) ? DIV_CYCLES : MULT_CYCLES;
  localparam int CNT_W   = $clog2(MAX_CYC + 1);

  md_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      pend_hi_q, pend_hi_d;
  logic [31:0]      pend_lo_q, pend_lo_d;
  logic             pend_dz_q, pend_dz_d;
  logic [31:0]      hi_q, hi_d;
  logic [31:0]      lo_q, lo_d;

  logic [31:0]      alu_hi;
  logic [31:0]      alu_lo;
  logic             alu_dz;

  md_alu u_alu (
    .op          (E_md_op),
    .rs          (E_rs_data),
    .rt          (E_rt_data),
    .hi          (alu_hi),
    .lo          (alu_lo),
    .div_by_zero (alu_dz)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= MD_IDLE;
      cnt_q     <= '0;
      pend_hi_q <= '0;
      pend_lo_q <= '0;
      pend_dz_q <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      pend_hi_q <= pend_hi_d;
      pend_lo_q <= pend_lo_d;
      pend_dz_q <= pend_dz_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    pend_hi_d = pend_hi_q;
    pend_lo_d = pend_lo_q;
    pend_dz_d = pend_dz_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    case (state_q)
      MD_IDLE: begin
        if (start) begin
          pend_hi_d = alu_hi;
          pend_lo_d = alu_lo;
          pend_dz_d = alu_dz;
          cnt_d     = (E_md_op == MD_MULT || E_md_op == MD_MULTU) ?
                      CNT_W'(MULT_CYCLES) : CNT_W'(DIV_CYCLES);
          state_d   = MD_RUN;
        end else if (E_valid) begin
          if (E_md_op == MD_MTHI) hi_d = E_rs_data;
          if (E_md_op == MD_MTLO) lo_d = E_rs_data;
        end
      end
      MD_RUN: begin
        cnt_d = cnt_q - 1'b1;
        // A zero divisor still burns the full period but never touches HI/LO.
        if (cnt_q == CNT_W'(1)) begin
          state_d = MD_IDLE;
          if (!pend_dz_q) begin
            hi_d = pend_hi_q;
            lo_d = pend_lo_q;
          end
        end
      end
      default: state_d = MD_IDLE;
    endcase
  end

  always_comb begin
    busy     = (cnt_q != '0);
    start    = E_valid & md_is_arith(E_md_op) & ~busy;
    stall_md = D_md_use & (start | busy);
    E_md_rd  = '0;
    if (E_valid) begin
      case (E_md_op)
        MD_MFHI: E_md_rd = hi_q;
        MD_MFLO: E_md_rd = lo_q;
        default: E_md_rd = '0;
      endcase
    end
  end

  assign HI = hi_q;
  assign LO = lo_q;

endmodule
